// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if
//   Handshake bundle between the four request sources and the round-robin
//   arbiter. The arbiter uses the slave modport. Whatever produces enable/req
//   and consumes the grant outputs uses the master modport.
//   Signals:
//     enable    arbitration enable (master -> slave)
//     req[3:0]  request vector     (master -> slave)
//     grant     one-hot grant      (slave -> master)
//     gnt_idx   current/last owner (slave -> master)
//     gnt_valid grant active       (slave -> master)
//     expired   hold-timeout pulse (slave -> master)
interface rr_grant_arbiter_if;
  logic       enable;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       expired;

  modport master (
    output enable, req,
    input  grant, gnt_idx, gnt_valid, expired
  );

  modport slave (
    input  enable, req,
    output grant, gnt_idx, gnt_valid, expired
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter
//   Four-way round-robin arbiter for one shared resource. An owner keeps the
//   grant while it keeps requesting. It can be preempted after MAX_HOLD
//   consecutive cycles, or by dropping enable. There is always one idle cycle
//   between owners. All outputs are registered.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  rr_grant_arbiter_if.slave: enable, req in; grant, gnt_idx,
//          gnt_valid, expired out
//   Parameters:
//     MAX_HOLD  maximum consecutive grant cycles (0 = unlimited)
module rr_grant_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_grant_arbiter_if.slave    bus
);
  // Hold-counter width is derived from MAX_HOLD and never less than 1 bit.
  localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t         state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic           valid_q, valid_d;
  logic [3:0]     grant_q, grant_d;
  logic           expired_q, expired_d;
  logic [HCW-1:0] hold_q, hold_d;

  logic [1:0]     winner;
  logic [3:0]     dec_d;
  logic           timeout;
  logic           owner_req;

  // Round-robin search starting just after the last owner. The loop runs from
  // the farthest candidate down to the nearest one, so the nearest requester
  // is the last one assigned and wins. k = 4 wraps back to the last owner
  // itself, which gives that owner the lowest priority.
  always_comb begin
    winner = idx_q;
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[idx_q + 2'(k)]) begin
        winner = idx_q + 2'(k);
      end
    end
  end

  assign owner_req = bus.req[idx_q];
  assign timeout   = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    expired_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.enable && (|bus.req)) begin
          state_d = S_GRANT;
          idx_d   = winner;
          valid_d = 1'b1;
          hold_d  = HCW'(1);
        end
      end
      S_GRANT: begin
        if (!bus.enable || !owner_req || timeout) begin
          state_d   = S_IDLE;
          valid_d   = 1'b0;
          // Flag a timeout only when it alone caused the release.
          expired_d = timeout && bus.enable && owner_req;
        end else if (MAX_HOLD != 0) begin
          hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HCW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Decode the next owner index so that the registered grant is always
  // consistent with gnt_idx and gnt_valid.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dec
    assign dec_d[gi] = (idx_d == 2'(gi));
  end
  assign grant_d = valid_d ? dec_d : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd3;
      valid_q   <= 1'b0;
      grant_q   <= 4'b0000;
      expired_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      grant_q   <= grant_d;
      expired_q <= expired_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.expired   = expired_q;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter
//   Drives three arbiters (MAX_HOLD = 8, 3, 0) with the same enable/req
//   stimulus. Each arbiter is compared every cycle against a behavioural
//   owner/queue model. Some scenarios also check fixed expected values.
module tb_rr_grant_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_grant_arbiter_if if0 ();
  rr_grant_arbiter_if if1 ();
  rr_grant_arbiter_if if2 ();

  rr_grant_arbiter #(.MAX_HOLD(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  rr_grant_arbiter #(.MAX_HOLD(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  rr_grant_arbiter #(.MAX_HOLD(0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic       en;
  logic [3:0] rq;
  assign if0.enable = en; assign if1.enable = en; assign if2.enable = en;
  assign if0.req    = rq; assign if1.req    = rq; assign if2.req    = rq;

  // Model state per arbiter. owner is -1 when nobody holds the resource.
  int mh    [3] = '{8, 3, 0};
  int owner [3];
  int last  [3];
  int held  [3];
  bit xp    [3];

  function automatic logic [7:0] obs(int d);
    case (d)
      0:       return {if0.grant, if0.gnt_idx, if0.gnt_valid, if0.expired};
      1:       return {if1.grant, if1.gnt_idx, if1.gnt_valid, if1.expired};
      default: return {if2.grant, if2.gnt_idx, if2.gnt_valid, if2.expired};
    endcase
  endfunction

  function automatic logic [7:0] expw(int d);
    logic [3:0] g;
    g = (owner[d] >= 0) ? (4'b0001 << owner[d]) : 4'b0000;
    return {g, 2'(last[d]), (owner[d] >= 0), xp[d]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      owner[d] = -1; last[d] = 3; held[d] = 0; xp[d] = 1'b0;
    end
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      xp[d] = 1'b0;
      if (owner[d] < 0) begin
        if (en && rq != 4'b0000) begin
          for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last[d] + k) % 4;
            if (rq[c]) begin
              owner[d] = c; last[d] = c; held[d] = 1;
              break;
            end
          end
        end
      end else if (!en || !rq[owner[d]]) begin
        owner[d] = -1;
      end else if (mh[d] != 0 && held[d] >= mh[d]) begin
        owner[d] = -1; xp[d] = 1'b1;
      end else begin
        held[d]++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    en = 1'b0; rq = 4'b0000; rst = 1'b1;
    model_reset();
    #12;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs(d) !== 8'b0000_11_0_0) begin
        miscompares++;
        $display("FAIL reset dut%0d: got %b want %b", d, obs(d), 8'b0000_11_0_0);
      end
    end
    @(negedge clk); rst = 1'b0;
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_single();
    en = 1'b1; rq = 4'b0001;
    step();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs(d) !== expw(d) || obs(d) !== 8'b0001_00_1_0) begin
        miscompares++;
        $display("FAIL single_grant dut%0d: got %b want %b", d, obs(d), 8'b0001_00_1_0);
      end
    end
    rq = 4'b0000;
    step();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs(d) !== expw(d) || obs(d) !== 8'b0000_00_0_0) begin
        miscompares++;
        $display("FAIL single_drop dut%0d: got %b want %b", d, obs(d), 8'b0000_00_0_0);
      end
    end
    step();
    $display("single requester grant/drop done at cycle %0d", cyc);
  endtask

  task automatic test_rotation();
    int pulses;
    pulses = 0;
    en = 1'b1; rq = 4'b1111;
    for (int i = 0; i < 40; i++) begin
      step();
      if (if1.expired === 1'b1) pulses++;
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (obs(d) !== expw(d)) begin
          miscompares++;
          $display("FAIL rotation dut%0d cyc%0d: got %b want %b", d, cyc, obs(d), expw(d));
        end
      end
    end
    // MAX_HOLD = 3 under full contention: a 4-cycle period, one expiry each.
    vectors++;
    if (pulses < 9 || pulses > 10) begin
      miscompares++;
      $display("FAIL rotation_expired_count: got %0d want 9..10", pulses);
    end
    $display("rotation with req=1111 done at cycle %0d", cyc);
  endtask

  task automatic test_handover();
    en = 1'b1; rq = 4'b0000;
    step(); step();
    rq = 4'b0100;
    step();
    rq = 4'b0101;
    step(); step();
    rq = 4'b0001;
    step();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs(d) !== expw(d) || obs(d) !== 8'b0000_10_0_0) begin
        miscompares++;
        $display("FAIL handover_gap dut%0d: got %b want %b", d, obs(d), 8'b0000_10_0_0);
      end
    end
    step();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs(d) !== expw(d) || obs(d) !== 8'b0001_00_1_0) begin
        miscompares++;
        $display("FAIL handover_next dut%0d: got %b want %b", d, obs(d), 8'b0001_00_1_0);
      end
    end
    $display("owner 2 -> owner 0 handover done at cycle %0d", cyc);
  endtask

  task automatic test_enable();
    en = 1'b1; rq = 4'b1111;
    step(); step();
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (obs(d) !== expw(d) || obs(d) !== {6'b0000_00 | {4'b0000, 2'(last[d])}, 2'b00}) begin
          miscompares++;
          $display("FAIL enable_low dut%0d cyc%0d: got %b want %b", d, cyc, obs(d), expw(d));
        end
      end
    end
    en = 1'b1;
    step();
    $display("enable drop done at cycle %0d", cyc);
  endtask

  task automatic test_reset_mid();
    en = 1'b1; rq = 4'b1111;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs(d) !== 8'b0000_11_0_0) begin
        miscompares++;
        $display("FAIL reset_mid dut%0d: got %b want %b", d, obs(d), 8'b0000_11_0_0);
      end
    end
    rq = 4'b1010;
    @(negedge clk); rst = 1'b0;
    step();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs(d) !== expw(d) || obs(d) !== 8'b0010_01_1_0) begin
        miscompares++;
        $display("FAIL reset_mid_first dut%0d: got %b want %b", d, obs(d), 8'b0010_01_1_0);
      end
    end
    $display("mid-grant reset done at cycle %0d", cyc);
  endtask

  task automatic test_random();
    en = 1'b1; rq = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) rq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) en = ~en;
      step();
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (obs(d) !== expw(d)) begin
          miscompares++;
          $display("FAIL random dut%0d cyc%0d en=%b req=%b: got %b want %b",
                   d, cyc, en, rq, obs(d), expw(d));
        end
      end
    end
    $display("random stimulus done at cycle %0d", cyc);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_handover();
    test_enable();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Round-robin arbiter that shares one resource among four requesters and drives a one-hot grant vector through a 2-to-4 binary decode of the winning index. It sits between four request sources and the shared datapath. It sequences ownership as follows: it holds a grant while the owner keeps requesting, optionally preempts after a bounded hold time, and always inserts one idle cycle between owners.

## Interface
- MAX_HOLD, default 8: maximum consecutive cycles a grant may be held; 0 = unlimited (no preemption).
- HCW, default $clog2(MAX_HOLD+1) (minimum 1): hold-counter width; derived, do not override.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  arbitration enable; low blocks new grants and forces release of any current grant.
- req  input  4  request vector; bit i high = requester i wants or keeps the resource.
- grant  output  4  one-hot grant; equals decode(gnt_idx) gated by gnt_valid; all-zero when no owner.
- gnt_idx  output  2  binary index of the current or last owner.
- gnt_valid  output  1  high while a grant is active.
- expired  output  1  one-cycle pulse: grant was removed by the MAX_HOLD timeout.

## Operation
- Two-state FSM: IDLE and GRANT. All outputs are registered.
- Reset (async, immediate):
  - state = IDLE, grant = 4'b0000, gnt_valid = 0, expired = 0.
  - gnt_idx = 2'd3, so that requester 0 has first priority.
  - hold counter = 0.
- IDLE:
  - If enable = 1 and req != 0, pick the winner by searching from gnt_idx+1 upward, modulo 4. The last owner has lowest priority.
  - On the next edge: load gnt_idx = winner, set gnt_valid = 1, set hold counter = 1, go to GRANT.
  - Otherwise stay in IDLE. gnt_idx keeps its value.
- GRANT, release conditions (first true wins, all evaluated on the same edge):
  - enable = 0.
  - req[gnt_idx] = 0.
  - MAX_HOLD != 0 and hold counter == MAX_HOLD. This is the only condition that sets expired = 1 for the following cycle, and only if enable and req[gnt_idx] are both still high.
- On release: next state = IDLE, gnt_valid = 0, grant = 0. gnt_idx keeps the released owner so that it gets lowest priority.
- No release: stay in GRANT and increment the hold counter, saturating at MAX_HOLD. With MAX_HOLD = 0 the counter is not used.
- expired is high for exactly one cycle and low otherwise.
- grant always equals (gnt_valid ? 1 << gnt_idx : 0). At most one bit is ever set.
- Other requesters' req changes during GRANT have no effect. There is no mid-grant preemption except the timeout and enable.

## Timing
- Grant latency: req sampled high in IDLE on edge N gives grant high after edge N (visible in cycle N+1).
- Release: a release condition seen on edge M gives grant low in cycle M+1 (the IDLE cycle). The earliest next grant is visible in cycle M+2.
- There is exactly one dead cycle between any two ownerships, including when the same requester wins again.
- The maximum continuous grant is MAX_HOLD cycles.
- Under continuous contention, each requester waits at most 3·(MAX_HOLD+1) cycles.
- Reset asserted mid-grant clears grant asynchronously in the same cycle. After reset deassertion the first arbitration happens on the first clock edge with enable = 1.

## Test plan
- Reset, then req = 4'b0001, enable = 1 → grant = 4'b0001 one cycle later, gnt_idx = 0. Drop req → grant = 0 the next cycle.
- req = 4'b1111 held, MAX_HOLD = 8 → grants 0, 1, 2, 3, 0, …: each high for 8 cycles, followed by a 1-cycle gap with expired = 1.
- Owner 2 active, req = 4'b0101 (requesters 0 and 2). Owner 2 drops at cycle M → idle at M+1, grant = 4'b0001 at M+2.
- Sole requester 1 holds with MAX_HOLD = 3 → pattern of 3 granted cycles then 1 gap, repeating. expired pulses each gap.
- enable dropped mid-grant → grant = 0 the next cycle, expired = 0. No grants while enable is low, even with req = 4'b1111.
- rst asserted mid-grant → grant, gnt_valid and expired go to 0 immediately, gnt_idx = 3. After reset with req = 4'b1010, requester 1 wins first.
